// File: rtl/operand_fetch_if.sv
// Decode-side and execute-side bundle of the operand fetch stage.
// master drives stage inputs, slave is the stage itself.
interface operand_fetch_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   i_dec_valid;
  logic                   o_dec_ready;
  logic [4:0]             i_rs1;
  logic [4:0]             i_rs2;
  logic [4:0]             i_rd;
  logic                   i_rd_write;
  logic [31:0]            i_pc;
  logic [31:0]            i_imm;
  logic [4:0]             o_rf_index1;
  logic [4:0]             o_rf_index2;
  logic [31:0]            i_rf_data1;
  logic [31:0]            i_rf_data2;
  logic                   i_wb_enable;
  logic [4:0]             i_wb_index;
  logic [31:0]            i_wb_data;
  logic                   i_flush;
  logic                   o_ex_valid;
  logic                   i_ex_ready;
  logic [31:0]            o_ex_rs1_data;
  logic [31:0]            o_ex_rs2_data;
  logic [31:0]            o_ex_pc;
  logic [31:0]            o_ex_imm;
  logic [4:0]             o_ex_rd;
  logic                   o_ex_rd_write;
  logic [STALL_CNT_W-1:0] o_stall_count;

  modport master (
    output i_dec_valid, i_rs1, i_rs2, i_rd, i_rd_write,
    output i_pc, i_imm, i_rf_data1, i_rf_data2,
    output i_wb_enable, i_wb_index, i_wb_data,
    output i_flush, i_ex_ready,
    input  o_dec_ready, o_rf_index1, o_rf_index2,
    input  o_ex_valid, o_ex_rs1_data, o_ex_rs2_data,
    input  o_ex_pc, o_ex_imm, o_ex_rd, o_ex_rd_write,
    input  o_stall_count
  );

  modport slave (
    input  i_dec_valid, i_rs1, i_rs2, i_rd, i_rd_write,
    input  i_pc, i_imm, i_rf_data1, i_rf_data2,
    input  i_wb_enable, i_wb_index, i_wb_data,
    input  i_flush, i_ex_ready,
    output o_dec_ready, o_rf_index1, o_rf_index2,
    output o_ex_valid, o_ex_rs1_data, o_ex_rs2_data,
    output o_ex_pc, o_ex_imm, o_ex_rd, o_ex_rd_write,
    output o_stall_count
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: RF read, writeback bypass,
// RAW scoreboard and registered slot toward execute.
module operand_fetch #(
  parameter bit FORWARD_WB  = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input logic           i_clk,
  input logic           i_rst_n,
  operand_fetch_if.slave bus
);

  logic [31:1] pending;
  logic [31:0] pend_vec;
  logic [31:0] pend_nxt;
  logic        fwd1;
  logic        fwd2;
  logic        hz1;
  logic        hz2;
  logic        accept;
  logic        issue;
  logic        stall_ev;
  logic [31:0] op1;
  logic [31:0] op2;

  assign pend_vec = {pending, 1'b0};

  assign bus.o_rf_index1 = bus.i_rs1;
  assign bus.o_rf_index2 = bus.i_rs2;

  // Writeback landing this cycle can be bypassed.
  always_comb begin
    fwd1 = FORWARD_WB && bus.i_wb_enable
        && (bus.i_wb_index == bus.i_rs1);
    fwd2 = FORWARD_WB && bus.i_wb_enable
        && (bus.i_wb_index == bus.i_rs2);
  end

  // RAW hazards against the scoreboard and the slot.
  always_comb begin
    hz1 = (bus.i_rs1 != 5'd0)
       && ((pend_vec[bus.i_rs1] && !fwd1)
        || (bus.o_ex_valid && bus.o_ex_rd_write
         && (bus.o_ex_rd == bus.i_rs1)));
    hz2 = (bus.i_rs2 != 5'd0)
       && ((pend_vec[bus.i_rs2] && !fwd2)
        || (bus.o_ex_valid && bus.o_ex_rd_write
         && (bus.o_ex_rd == bus.i_rs2)));
  end

  assign bus.o_dec_ready = !bus.i_flush && !hz1 && !hz2
                        && (!bus.o_ex_valid || bus.i_ex_ready);
  assign accept   = bus.i_dec_valid && bus.o_dec_ready;
  assign issue    = bus.o_ex_valid && bus.i_ex_ready
                 && !bus.i_flush;
  assign stall_ev = bus.i_dec_valid && !bus.i_flush
                 && (hz1 || hz2);

  // Operand select: x0, bypass, then register file.
  always_comb begin
    op1 = bus.i_rf_data1;
    op2 = bus.i_rf_data2;
    if (bus.i_rs1 == 5'd0) op1 = '0;
    else if (fwd1)         op1 = bus.i_wb_data;
    if (bus.i_rs2 == 5'd0) op2 = '0;
    else if (fwd2)         op2 = bus.i_wb_data;
  end

  // Scoreboard update; issue set applied after the clear.
  always_comb begin
    pend_nxt = pend_vec;
    if (bus.i_wb_enable)
      pend_nxt[bus.i_wb_index] = 1'b0;
    if (issue && bus.o_ex_rd_write)
      pend_nxt[bus.o_ex_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) pending <= '0;
    else          pending <= pend_nxt[31:1];
  end

  // Output slot toward execute.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.o_ex_valid    <= 1'b0;
      bus.o_ex_rs1_data <= '0;
      bus.o_ex_rs2_data <= '0;
      bus.o_ex_pc       <= '0;
      bus.o_ex_imm      <= '0;
      bus.o_ex_rd       <= '0;
      bus.o_ex_rd_write <= 1'b0;
    end else if (accept) begin
      bus.o_ex_valid    <= 1'b1;
      bus.o_ex_rs1_data <= op1;
      bus.o_ex_rs2_data <= op2;
      bus.o_ex_pc       <= bus.i_pc;
      bus.o_ex_imm      <= bus.i_imm;
      bus.o_ex_rd       <= bus.i_rd;
      bus.o_ex_rd_write <= bus.i_rd_write;
    end else if (bus.i_ex_ready || bus.i_flush) begin
      bus.o_ex_valid    <= 1'b0;
    end
  end

  // Saturating count of hazard stall cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      bus.o_stall_count <= '0;
    else if (stall_ev && !(&bus.o_stall_count))
      bus.o_stall_count <= bus.o_stall_count + 1'b1;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: both bypass variants share one
// stimulus stream; directed scenarios plus a randomized model run.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid, rd_write, wb_en, flush, ex_ready;
  logic [4:0]  rs1, rs2, rd, wb_idx;
  logic [31:0] pc, imm, wb_data;
  logic        ff1 = 1'b0;
  logic [31:0] rf [32];
  int          n_pass = 0;
  int          n_total = 0;

  operand_fetch_if #(.STALL_CNT_W(16)) a_if ();
  operand_fetch_if #(.STALL_CNT_W(16)) b_if ();

  operand_fetch #(.FORWARD_WB(1'b1), .STALL_CNT_W(16)) a_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(a_if.slave));
  operand_fetch #(.FORWARD_WB(1'b0), .STALL_CNT_W(16)) b_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b_if.slave));

  always #5 clk = ~clk;

  assign a_if.i_dec_valid = dec_valid;
  assign b_if.i_dec_valid = dec_valid;
  assign a_if.i_rs1 = rs1;
  assign b_if.i_rs1 = rs1;
  assign a_if.i_rs2 = rs2;
  assign b_if.i_rs2 = rs2;
  assign a_if.i_rd = rd;
  assign b_if.i_rd = rd;
  assign a_if.i_rd_write = rd_write;
  assign b_if.i_rd_write = rd_write;
  assign a_if.i_pc = pc;
  assign b_if.i_pc = pc;
  assign a_if.i_imm = imm;
  assign b_if.i_imm = imm;
  assign a_if.i_wb_enable = wb_en;
  assign b_if.i_wb_enable = wb_en;
  assign a_if.i_wb_index = wb_idx;
  assign b_if.i_wb_index = wb_idx;
  assign a_if.i_wb_data = wb_data;
  assign b_if.i_wb_data = wb_data;
  assign a_if.i_flush = flush;
  assign b_if.i_flush = flush;
  assign a_if.i_ex_ready = ex_ready;
  assign b_if.i_ex_ready = ex_ready;
  assign a_if.i_rf_data1 = ff1 ? 32'hFFFF_FFFF : rf[a_if.o_rf_index1];
  assign a_if.i_rf_data2 = rf[a_if.o_rf_index2];
  assign b_if.i_rf_data1 = ff1 ? 32'hFFFF_FFFF : rf[b_if.o_rf_index1];
  assign b_if.i_rf_data2 = rf[b_if.o_rf_index2];

  // Register file model written on the clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en && wb_idx != 5'd0) begin
      rf[wb_idx] <= wb_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rd_write = 0;
    pc = 0; imm = 0; wb_en = 0; wb_idx = 0; wb_data = 0;
    flush = 0; ex_ready = 1; ff1 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    dec_valid = 1;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    #1;
    n_total++;
    if (a_if.o_ex_valid !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", a_if.o_ex_valid);
    else n_pass++;
    n_total++;
    if (a_if.o_stall_count !== 16'd0)
      $display("FAIL reset_stall: got %0d want 0", a_if.o_stall_count);
    else n_pass++;
    n_total++;
    if (a_if.o_dec_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", a_if.o_dec_ready);
    else n_pass++;
    n_total++;
    if ({a_if.o_ex_pc, a_if.o_ex_imm, a_if.o_ex_rs1_data,
         a_if.o_ex_rd, a_if.o_ex_rd_write} !== '0)
      $display("FAIL reset_fields: got %h want 0",
               {a_if.o_ex_pc, a_if.o_ex_imm, a_if.o_ex_rd});
    else n_pass++;
    dec_valid = 0;
  endtask

  task automatic test_forward();
    int n;
    n = $urandom_range(1, 3);
    do_reset();
    dec_valid = 1; rd = 5; rd_write = 1;
    step();
    rs1 = 5; rd = 6; rd_write = 0; pc = 32'h100;
    #1;
    n_total++;
    if (a_if.o_dec_ready !== 1'b0)
      $display("FAIL fwd_slot_hazard: got %b want 0", a_if.o_dec_ready);
    else n_pass++;
    step();
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (a_if.o_dec_ready !== 1'b0 || b_if.o_dec_ready !== 1'b0)
        $display("FAIL fwd_wait: got %b%b want 00",
                 a_if.o_dec_ready, b_if.o_dec_ready);
      else n_pass++;
      step();
    end
    wb_en = 1; wb_idx = 5; wb_data = 32'hDEADBEEF;
    #1;
    n_total++;
    if (a_if.o_dec_ready !== 1'b1 || b_if.o_dec_ready !== 1'b0)
      $display("FAIL fwd_wb_cycle: got %b%b want 10",
               a_if.o_dec_ready, b_if.o_dec_ready);
    else n_pass++;
    step();
    wb_en = 0; wb_data = 0;
    n_total++;
    if (a_if.o_ex_valid !== 1'b1 || a_if.o_ex_rs1_data !== 32'hDEADBEEF)
      $display("FAIL fwd_data: got %b %h want 1 deadbeef",
               a_if.o_ex_valid, a_if.o_ex_rs1_data);
    else n_pass++;
    n_total++;
    if (a_if.o_stall_count !== 16'(n + 1))
      $display("FAIL fwd_stall: got %0d want %0d",
               a_if.o_stall_count, n + 1);
    else n_pass++;
    #1;
    n_total++;
    if (b_if.o_dec_ready !== 1'b1)
      $display("FAIL nofwd_ready: got %b want 1", b_if.o_dec_ready);
    else n_pass++;
    step();
    dec_valid = 0;
    n_total++;
    if (b_if.o_ex_valid !== 1'b1 || b_if.o_ex_rs1_data !== 32'hDEADBEEF)
      $display("FAIL nofwd_data: got %b %h want 1 deadbeef",
               b_if.o_ex_valid, b_if.o_ex_rs1_data);
    else n_pass++;
    n_total++;
    if (b_if.o_stall_count !== 16'(n + 2))
      $display("FAIL nofwd_stall: got %0d want %0d",
               b_if.o_stall_count, n + 2);
    else n_pass++;
  endtask

  task automatic test_x0();
    do_reset();
    dec_valid = 1; rd = 0; rd_write = 1;
    step();
    ff1 = 1; rs1 = 0; rd = 2; rd_write = 0;
    #1;
    n_total++;
    if (a_if.o_dec_ready !== 1'b1)
      $display("FAIL x0_ready: got %b want 1", a_if.o_dec_ready);
    else n_pass++;
    step();
    dec_valid = 0;
    n_total++;
    if (a_if.o_ex_valid !== 1'b1 || a_if.o_ex_rs1_data !== 32'd0)
      $display("FAIL x0_data: got %b %h want 1 0",
               a_if.o_ex_valid, a_if.o_ex_rs1_data);
    else n_pass++;
    n_total++;
    if (a_if.o_stall_count !== 16'd0)
      $display("FAIL x0_stall: got %0d want 0", a_if.o_stall_count);
    else n_pass++;
    ff1 = 0;
  endtask

  task automatic test_backpressure_flush();
    logic [31:0] p, m;
    p = $urandom; m = $urandom;
    do_reset();
    ex_ready = 0;
    dec_valid = 1; rd = 9; rd_write = 1; pc = p; imm = m;
    step();
    rd = 3; pc = ~p; imm = ~m;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (a_if.o_dec_ready !== 1'b0 || a_if.o_ex_valid !== 1'b1
          || a_if.o_ex_pc !== p || a_if.o_ex_imm !== m
          || a_if.o_ex_rd !== 5'd9 || a_if.o_ex_rd_write !== 1'b1)
        $display("FAIL bp_hold: got %b %h %h %0d want 0 %h %h 9",
                 a_if.o_dec_ready, a_if.o_ex_pc, a_if.o_ex_imm,
                 a_if.o_ex_rd, p, m);
      else n_pass++;
      step();
    end
    flush = 1;
    step();
    flush = 0;
    n_total++;
    if (a_if.o_ex_valid !== 1'b0)
      $display("FAIL flush_valid: got %b want 0", a_if.o_ex_valid);
    else n_pass++;
    ex_ready = 1; rs1 = 9;
    #1;
    n_total++;
    if (a_if.o_dec_ready !== 1'b1)
      $display("FAIL flush_no_pend: got %b want 1", a_if.o_dec_ready);
    else n_pass++;
    n_total++;
    if (a_if.o_stall_count !== 16'd0)
      $display("FAIL bp_stall: got %0d want 0", a_if.o_stall_count);
    else n_pass++;
    dec_valid = 0;
    step();
  endtask

  task automatic test_set_clear();
    logic [31:0] d;
    d = $urandom;
    do_reset();
    dec_valid = 1; rd = 7; rd_write = 1;
    step();
    dec_valid = 0; rd_write = 0;
    wb_en = 1; wb_idx = 7; wb_data = 32'h1234;
    step();
    wb_en = 0;
    dec_valid = 1; rs2 = 7; rd = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if (a_if.o_dec_ready !== 1'b0)
        $display("FAIL sc_stall: got %b want 0", a_if.o_dec_ready);
      else n_pass++;
      step();
    end
    wb_en = 1; wb_idx = 7; wb_data = d;
    #1;
    n_total++;
    if (a_if.o_dec_ready !== 1'b1)
      $display("FAIL sc_release: got %b want 1", a_if.o_dec_ready);
    else n_pass++;
    step();
    wb_en = 0; dec_valid = 0;
    n_total++;
    if (a_if.o_ex_rs2_data !== d || a_if.o_stall_count !== 16'd2)
      $display("FAIL sc_data: got %h %0d want %h 2",
               a_if.o_ex_rs2_data, a_if.o_stall_count, d);
    else n_pass++;
  endtask

  task automatic test_random();
    bit          pend [32];
    bit          mv, mrdw, h1, h2, exp_rdy, iss, acc, found;
    logic [4:0]  mrd;
    logic [31:0] m1, m2, mpc, mimm, e1, e2;
    int          mstall, start, idx;
    do_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    mv = 0; mrdw = 0; mrd = 0; mstall = 0;
    m1 = 0; m2 = 0; mpc = 0; mimm = 0;
    for (int c = 0; c < 400; c++) begin
      dec_valid = $urandom_range(0, 9) < 8;
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      rd_write = $urandom_range(0, 3) != 0;
      pc = $urandom; imm = $urandom;
      ex_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      wb_en = 0; wb_idx = 0; wb_data = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        found = 0;
        start = $urandom_range(0, 30);
        for (int k = 0; k < 31; k++) begin
          idx = (start + k) % 31 + 1;
          if (!found && pend[idx]) begin
            found = 1; wb_en = 1; wb_idx = 5'(idx);
          end
        end
      end else if ($urandom_range(0, 19) == 0) begin
        wb_en = 1; wb_idx = 5'($urandom_range(0, 31));
      end
      #1;
      h1 = rs1 != 0 && ((pend[rs1] && !(wb_en && wb_idx == rs1))
           || (mv && mrdw && mrd == rs1));
      h2 = rs2 != 0 && ((pend[rs2] && !(wb_en && wb_idx == rs2))
           || (mv && mrdw && mrd == rs2));
      exp_rdy = !flush && !h1 && !h2 && (!mv || ex_ready);
      n_total++;
      if (a_if.o_dec_ready !== exp_rdy || a_if.o_rf_index1 !== rs1
          || a_if.o_rf_index2 !== rs2)
        $display("FAIL rnd_ready c%0d: got %b %0d %0d want %b %0d %0d",
                 c, a_if.o_dec_ready, a_if.o_rf_index1,
                 a_if.o_rf_index2, exp_rdy, rs1, rs2);
      else n_pass++;
      e1 = rs1 == 0 ? 0 : (wb_en && wb_idx == rs1) ? wb_data : rf[rs1];
      e2 = rs2 == 0 ? 0 : (wb_en && wb_idx == rs2) ? wb_data : rf[rs2];
      iss = mv && ex_ready && !flush;
      acc = dec_valid && exp_rdy;
      if (wb_en) pend[wb_idx] = 0;
      if (iss && mrdw && mrd != 0) pend[mrd] = 1;
      if (dec_valid && !flush && (h1 || h2) && mstall < 65535)
        mstall++;
      if (acc) begin
        mv = 1; m1 = e1; m2 = e2; mpc = pc; mimm = imm;
        mrd = rd; mrdw = rd_write;
      end else if (ex_ready || flush) begin
        mv = 0;
      end
      step();
      n_total++;
      if (a_if.o_ex_valid !== mv || a_if.o_stall_count !== 16'(mstall))
        $display("FAIL rnd_slot c%0d: got %b %0d want %b %0d", c,
                 a_if.o_ex_valid, a_if.o_stall_count, mv, mstall);
      else n_pass++;
      if (mv) begin
        n_total++;
        if (a_if.o_ex_rs1_data !== m1 || a_if.o_ex_rs2_data !== m2
            || a_if.o_ex_pc !== mpc || a_if.o_ex_imm !== mimm
            || a_if.o_ex_rd !== mrd || a_if.o_ex_rd_write !== mrdw)
          $display("FAIL rnd_fields c%0d: got %h %h %h want %h %h %h",
                   c, a_if.o_ex_rs1_data, a_if.o_ex_rs2_data,
                   a_if.o_ex_pc, m1, m2, mpc);
        else n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_forward();
    test_x0();
    test_backpressure_flush();
    test_set_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage between decode and execute.
- Drives both register file read indices combinationally and bypasses same-cycle writeback data, since the register file writes on the clock edge.
- Tracks outstanding destination writes in a 31-entry scoreboard and stalls decode on read-after-write hazards.
- Registers operands plus control into a valid/ready output slot for execute.

Parameters:
- FORWARD_WB, 1: 1 = bypass i_wb_data when i_wb_index matches a source; 0 = stall until the cycle after the write.
- STALL_CNT_W, 16: width of the saturating hazard-stall counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_dec_valid  in  1  decode has an instruction
- o_dec_ready  out  1  stage accepts the decode instruction
- i_rs1, i_rs2, i_rd  in  5 each  source and destination indices
- i_rd_write  in  1  instruction writes rd
- i_pc, i_imm  in  32 each  passed through to execute
- o_rf_index1, o_rf_index2  out  5 each  register file read indices
- i_rf_data1, i_rf_data2  in  32 each  register file read data
- i_wb_enable, i_wb_index, i_wb_data  in  1/5/32  writeback port, same signals the register file sees
- i_flush  in  1  kill the output slot and refuse decode this cycle
- o_ex_valid  out  1  output slot holds an instruction
- i_ex_ready  in  1  execute accepts the slot
- o_ex_rs1_data, o_ex_rs2_data, o_ex_pc, o_ex_imm  out  32 each  registered operands and passthrough fields
- o_ex_rd  out  5  registered destination index
- o_ex_rd_write  out  1  registered destination-write flag
- o_stall_count  out  STALL_CNT_W  hazard-stall cycle counter

Behaviour:
- Reset: i_clk is the single clock; i_rst_n is synchronous, active-low. On reset, all scoreboard bits = 0, o_ex_valid = 0, every o_ex_* field = 0, o_stall_count = 0.
- Register file indices: o_rf_index1 = i_rs1 and o_rf_index2 = i_rs2, purely combinational.
- Source hazard: for each source rs != 0, hazard if either of these holds:
  - (a) pending[rs] = 1 and not (FORWARD_WB = 1 and i_wb_enable and i_wb_index = rs);
  - (b) o_ex_valid and o_ex_rd_write and o_ex_rd = rs.
  - rs = 0 never causes a hazard.
- Handshake:
  - o_dec_ready = !i_flush && !hazard1 && !hazard2 && (!o_ex_valid || i_ex_ready).
  - Decode accept = i_dec_valid && o_dec_ready; the output slot loads on the next edge.
- Operand select per source:
  - rs = 0 → 0;
  - else if i_wb_enable and i_wb_index = rs (FORWARD_WB = 1) → i_wb_data;
  - else → i_rf_data.
- Output slot:
  - On decode accept: o_ex_valid <= 1, all fields loaded.
  - Else if i_ex_ready or i_flush: o_ex_valid <= 0; fields hold their values.
  - Flush takes priority over accept; o_dec_ready is already 0 under flush.
- Scoreboard, 31 bits, x0 not stored:
  - Set pending[o_ex_rd] on an execute handshake (o_ex_valid && i_ex_ready && !i_flush) when o_ex_rd_write && o_ex_rd != 0.
  - Clear pending[i_wb_index] when i_wb_enable and i_wb_index != 0.
  - Same index set and cleared in the same cycle → set wins, because the issuing instruction is younger.
  - Writeback to a non-pending index is legal and has no effect.
  - i_flush does not clear scoreboard bits; issued instructions always write back.
- Stall counter: increments by 1 in each cycle where i_dec_valid && !i_flush && (hazard1 || hazard2). It saturates at all-ones.
- Back-to-back dependent instructions: with FORWARD_WB = 1, the dependent instruction is accepted in the producer's writeback cycle.

Test Plan:
- Reset with i_dec_valid = 1 → o_ex_valid = 0, o_stall_count = 0, o_dec_ready = 1 on the first post-reset cycle when rs1 = rs2 = 0.
- Writeback forwarding, FORWARD_WB = 1:
  - Issue "x5 <- ..." and let execute accept it; present rs1 = 5.
  - Result → o_dec_ready = 0 until i_wb_enable = 1, i_wb_index = 5, i_wb_data = 0xDEADBEEF.
  - Accepted in that cycle; o_ex_rs1_data = 0xDEADBEEF next cycle.
  - o_stall_count equals the number of wait cycles.
- Same test with FORWARD_WB = 0 → accept occurs one cycle after the writeback; data is taken from i_rf_data1.
- x0 handling: rd = 0 with rd_write = 1 issued, then rs1 = 0 → no stall, no scoreboard bit set, o_ex_rs1_data = 0 even if i_rf_data1 = 0xFFFFFFFF.
- Execute back-pressure and flush:
  - Hold i_ex_ready = 0 with the slot valid → o_dec_ready = 0 and all o_ex_* fields stable.
  - Assert i_flush → o_ex_valid = 0 next cycle; the pending bit for that slot's rd stays clear.
- Same-cycle set and clear of x7 (issue of rd = 7 plus writeback of 7) → pending[7] = 1 afterwards; a later rs2 = 7 stalls until the next writeback to 7.
